// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding, row drive and ASCII map for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] ROW_N_RESET = 4'b1110;

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // A sample counts only when exactly one column is pulled low.
    function automatic logic col_one_low(input logic [3:0] col_n);
        case (col_n)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] col_n);
        case (col_n)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] key_ascii(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'd0:    return 8'h31;
            4'd1:    return 8'h32;
            4'd2:    return 8'h33;
            4'd3:    return 8'h41;
            4'd4:    return 8'h34;
            4'd5:    return 8'h35;
            4'd6:    return 8'h36;
            4'd7:    return 8'h42;
            4'd8:    return 8'h37;
            4'd9:    return 8'h38;
            4'd10:   return 8'h39;
            4'd11:   return 8'h43;
            4'd12:   return 8'h2A;
            4'd13:   return 8'h30;
            4'd14:   return 8'h23;
            default: return 8'h44;
        endcase
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// rtl/keypad_scan_tick.sv - SCAN_DIV prescaler producing a one-clock scan tick at wrap
module keypad_scan_tick import keypad_pkg::*; #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with debounce and one strobe per press
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scanner import keypad_pkg::*; #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [7:0] key_code,
    output logic       key_trigger,
    output logic       key_busy
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CNT);

    logic          tick;
    logic [3:0]    col_meta;
    logic [3:0]    col_sync;
    state_t        state;
    logic [1:0]    row_idx;
    logic [1:0]    col_lat;
    logic [CW-1:0] deb_cnt;
    logic [CW-1:0] rel_cnt;
    logic          sample_ok;
    logic [1:0]    sample_col;
    logic [1:0]    next_row;

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_first;
    logic [RW-1:0] rep_next;
    logic [RW-1:0] rep_limit;

    assign rep_next  = rep_cnt + RW'(1);
    assign rep_limit = rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
`endif

    keypad_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    assign sample_ok  = col_one_low(col_sync);
    assign sample_col = col_index(col_sync);
    assign next_row   = row_idx + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SCAN;
            row_idx     <= 2'd0;
            row_n       <= ROW_N_RESET;
            col_lat     <= 2'd0;
            deb_cnt     <= '0;
            rel_cnt     <= '0;
            key_code    <= 8'h00;
            key_trigger <= 1'b0;
            key_busy    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
`endif
        end else begin
            key_trigger <= 1'b0;
            if (tick) begin
                unique case (state)
                    SCAN: begin
                        if (sample_ok) begin
                            col_lat  <= sample_col;
                            key_busy <= 1'b1;
                            if (CNT_DONE == CW'(1)) begin
                                key_code    <= key_ascii(row_idx, sample_col);
                                key_trigger <= 1'b1;
                                deb_cnt     <= '0;
                                rel_cnt     <= '0;
                                state       <= HELD;
                            end else begin
                                deb_cnt <= CW'(1);
                                state   <= DEBOUNCE;
                            end
                        end else begin
                            row_idx <= next_row;
                            row_n   <= row_drive(next_row);
                        end
                    end
                    DEBOUNCE: begin
                        if (sample_ok && sample_col == col_lat) begin
                            if (deb_cnt + CW'(1) == CNT_DONE) begin
                                key_code    <= key_ascii(row_idx, col_lat);
                                key_trigger <= 1'b1;
                                deb_cnt     <= '0;
                                rel_cnt     <= '0;
                                state       <= HELD;
                            end else begin
                                deb_cnt <= deb_cnt + CW'(1);
                            end
                        end else begin
                            deb_cnt  <= '0;
                            key_busy <= 1'b0;
                            state    <= SCAN;
                            row_idx  <= next_row;
                            row_n    <= row_drive(next_row);
                        end
                    end
                    HELD: begin
                        if (col_sync[col_lat]) begin
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt   <= '0;
                            rep_first <= 1'b1;
`endif
                            if (rel_cnt + CW'(1) == CNT_DONE) begin
                                rel_cnt  <= '0;
                                key_busy <= 1'b0;
                                state    <= SCAN;
                                row_idx  <= next_row;
                                row_n    <= row_drive(next_row);
                            end else begin
                                rel_cnt <= rel_cnt + CW'(1);
                            end
                        end else begin
                            rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                            // First repeat after REPEAT_DELAY ticks, then every REPEAT_RATE.
                            if (rep_next == rep_limit) begin
                                key_trigger <= 1'b1;
                                rep_cnt     <= '0;
                                rep_first   <= 1'b0;
                            end else begin
                                rep_cnt <= rep_next;
                            end
`endif
                        end
                    end
                    default: begin
                        state    <= SCAN;
                        key_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
